// File: rtl/pipelined_cpu.sv
// pipelined_cpu: five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset core.
//   clk_i   : system clock, rising edge
//   rst_i   : async active-low reset; clears PC and all pipeline registers
//   start_i : run enable; while low the whole pipeline and all writes freeze
// Programs/data live in the Instruction_Memory / DATAMEMORY instances and
// results are observed through Registers.register.
// ISA: add sub and or mul (R-type), addi, lw, sw, beq, j; others are NOPs.

package pipelined_cpu_pkg;
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic regdst;
    logic alur;      // R-type: ALU op comes from funct, else add
  } ctrl_t;
endpackage

// Program counter register.
module pc_reg (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n)    pc_o <= '0;
    else if (en_i) pc_o <= pc_i;
endmodule

// Instruction ROM, word indexed, combinational read. The load port exists
// so the array has a driver; the top ties it off and programs are preloaded.
module instr_mem (
  input  logic        clk_i,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] instr_o
);
  logic [31:0] memory [0:255];
  always @(posedge clk_i)
    if (we_i) memory[waddr_i] <= wdata_i;
  assign instr_o = memory[addr_i];
endmodule

// 32x32 register file, r0 hardwired to zero, write-first read bypass.
module reg_file (
  input  logic        clk_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];
  logic wr;
  assign wr = we_i && (wa_i != 5'd0);
  always @(posedge clk_i)
    if (wr) register[wa_i] <= wd_i;
  assign rd1_o = (rs_i == 5'd0) ? '0 : (wr && wa_i == rs_i) ? wd_i : register[rs_i];
  assign rd2_o = (rt_i == 5'd0) ? '0 : (wr && wa_i == rt_i) ? wd_i : register[rt_i];
endmodule

// 32-byte little-endian data memory; word aligned, combinational read.
module data_mem (
  input  logic        clk_i,
  input  logic [2:0]  widx_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [7:0] out [0:31];
  always @(posedge clk_i)
    if (we_i) begin
      out[{widx_i, 2'd0}] <= wdata_i[7:0];
      out[{widx_i, 2'd1}] <= wdata_i[15:8];
      out[{widx_i, 2'd2}] <= wdata_i[23:16];
      out[{widx_i, 2'd3}] <= wdata_i[31:24];
    end
  assign rdata_o = {out[{widx_i, 2'd3}], out[{widx_i, 2'd2}],
                    out[{widx_i, 2'd1}], out[{widx_i, 2'd0}]};
endmodule

// Main decoder.
module control (
  input  logic [5:0]                 op_i,
  output pipelined_cpu_pkg::ctrl_t   ctrl_o,
  output logic                       branch_o,
  output logic                       jump_o
);
  always_comb begin
    ctrl_o   = '0;
    branch_o = 1'b0;
    jump_o   = 1'b0;
    case (op_i)
      6'h00: begin ctrl_o.regwrite = 1'b1; ctrl_o.regdst = 1'b1; ctrl_o.alur = 1'b1; end
      6'h08: begin ctrl_o.regwrite = 1'b1; ctrl_o.alusrc = 1'b1; end
      6'h23: begin ctrl_o.regwrite = 1'b1; ctrl_o.memtoreg = 1'b1;
                   ctrl_o.memread  = 1'b1; ctrl_o.alusrc   = 1'b1; end
      6'h2B: begin ctrl_o.memwrite = 1'b1; ctrl_o.alusrc = 1'b1; end
      6'h04: branch_o = 1'b1;
      6'h02: jump_o   = 1'b1;
      default: ;
    endcase
  end
endmodule

// Load-use detector: mux8_o=0 requests a bubble.
module hazard (
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       mux8_o
);
  assign mux8_o = !(idex_memread_i && (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i));
endmodule

// ID-stage register comparator for beq.
module equal (
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        data_o
);
  assign data_o = (data1_i == data2_i);
endmodule

module pipelined_cpu
  import pipelined_cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  // IF
  logic [31:0] pc, pc4, pc_next, instr;
  // IF/ID
  logic [31:0] ifid_pc4, ifid_instr;
  // ID
  logic [31:0] id_rd1, id_rd2, id_sext, target;
  ctrl_t       id_c;
  logic        id_branch, id_jump, id_eq, take, mux8, stall;
  // ID/EX
  ctrl_t       idex_c;
  logic [31:0] idex_rd1, idex_rd2, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  // EX
  logic [31:0] fa, fb, alu_b, alu;
  logic [4:0]  ex_wreg;
  // EX/MEM
  logic        exmem_regwrite, exmem_memtoreg, exmem_memwrite;
  logic [31:0] exmem_alu, exmem_sd, mem_rdata;
  logic [4:0]  exmem_wreg;
  // MEM/WB
  logic        memwb_regwrite, memwb_memtoreg;
  logic [31:0] memwb_rdata, memwb_alu, wb_data;
  logic [4:0]  memwb_wreg;

  assign pc4     = pc + 32'd4;
  // Redirect wins over a load-use stall.
  assign take    = id_jump || (id_branch && id_eq);
  assign stall   = !mux8 && !take;
  assign id_sext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  assign target  = id_jump ? {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}
                           : ifid_pc4 + {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
  assign pc_next = take ? target : stall ? pc : pc4;

  pc_reg PC (.clk_i(clk_i), .rst_n(rst_i), .en_i(start_i), .pc_i(pc_next), .pc_o(pc));

  instr_mem Instruction_Memory (.clk_i(clk_i), .addr_i(pc[9:2]), .we_i(1'b0),
    .waddr_i(8'd0), .wdata_i(32'd0), .instr_o(instr));

  reg_file Registers (.clk_i(clk_i), .rs_i(ifid_instr[25:21]), .rt_i(ifid_instr[20:16]),
    .we_i(memwb_regwrite && start_i), .wa_i(memwb_wreg), .wd_i(wb_data),
    .rd1_o(id_rd1), .rd2_o(id_rd2));

  control Control (.op_i(ifid_instr[31:26]), .ctrl_o(id_c),
    .branch_o(id_branch), .jump_o(id_jump));

  hazard HD (.idex_memread_i(idex_c.memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_instr[25:21]), .ifid_rt_i(ifid_instr[20:16]), .mux8_o(mux8));

  equal EQ (.data1_i(id_rd1), .data2_i(id_rd2), .data_o(id_eq));

  // Forwarding: EX/MEM first, then MEM/WB; never from r0.
  always_comb begin
    fa = idex_rd1;
    fb = idex_rd2;
    if (exmem_regwrite && exmem_wreg != 5'd0 && exmem_wreg == idex_rs)      fa = exmem_alu;
    else if (memwb_regwrite && memwb_wreg != 5'd0 && memwb_wreg == idex_rs) fa = wb_data;
    if (exmem_regwrite && exmem_wreg != 5'd0 && exmem_wreg == idex_rt)      fb = exmem_alu;
    else if (memwb_regwrite && memwb_wreg != 5'd0 && memwb_wreg == idex_rt) fb = wb_data;
  end

  assign alu_b   = idex_c.alusrc ? idex_imm : fb;
  assign ex_wreg = idex_c.regdst ? idex_rd : idex_rt;

  always_comb begin
    alu = fa + alu_b;
    if (idex_c.alur)
      case (idex_imm[5:0])
        6'h20:   alu = fa + alu_b;
        6'h22:   alu = fa - alu_b;
        6'h24:   alu = fa & alu_b;
        6'h25:   alu = fa | alu_b;
        6'h18:   alu = fa * alu_b;
        default: alu = '0;
      endcase
  end

  data_mem DATAMEMORY (.clk_i(clk_i), .widx_i(exmem_alu[4:2]),
    .we_i(exmem_memwrite && start_i), .wdata_i(exmem_sd), .rdata_o(mem_rdata));

  assign wb_data = memwb_memtoreg ? memwb_rdata : memwb_alu;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ifid_pc4 <= '0; ifid_instr <= '0;
      idex_c <= '0; idex_rd1 <= '0; idex_rd2 <= '0; idex_imm <= '0;
      idex_rs <= '0; idex_rt <= '0; idex_rd <= '0;
      exmem_regwrite <= 1'b0; exmem_memtoreg <= 1'b0; exmem_memwrite <= 1'b0;
      exmem_alu <= '0; exmem_sd <= '0; exmem_wreg <= '0;
      memwb_regwrite <= 1'b0; memwb_memtoreg <= 1'b0;
      memwb_rdata <= '0; memwb_alu <= '0; memwb_wreg <= '0;
    end else if (start_i) begin
      if (take) begin
        ifid_pc4 <= '0; ifid_instr <= '0;
      end else if (!stall) begin
        ifid_pc4 <= pc4; ifid_instr <= instr;
      end
      idex_c   <= mux8 ? id_c : '0;
      idex_rd1 <= id_rd1; idex_rd2 <= id_rd2; idex_imm <= id_sext;
      idex_rs  <= ifid_instr[25:21];
      idex_rt  <= ifid_instr[20:16];
      idex_rd  <= ifid_instr[15:11];
      exmem_regwrite <= idex_c.regwrite;
      exmem_memtoreg <= idex_c.memtoreg;
      exmem_memwrite <= idex_c.memwrite;
      exmem_alu <= alu; exmem_sd <= fb; exmem_wreg <= ex_wreg;
      memwb_regwrite <= exmem_regwrite;
      memwb_memtoreg <= exmem_memtoreg;
      memwb_rdata <= mem_rdata; memwb_alu <= exmem_alu; memwb_wreg <= exmem_wreg;
    end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Bench for pipelined_cpu: preloads small programs, queues expected PC
// values and final register/memory contents, compares as the core runs.
module tb_pipelined_cpu;
  logic clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
  always #5 clk_i = ~clk_i;

  pipelined_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  int errs = 0, checks = 0;
  int stalls, flushes;

  typedef struct {
    string       tag;
    bit          mem;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] pcq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rt_i(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rt, rs,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic exp_reg(input string tag, input int r, input logic [31:0] v);
    exp_t e; e.tag = tag; e.mem = 1'b0; e.idx = r; e.val = v; sb.push_back(e);
  endtask
  task automatic exp_mem(input string tag, input int a, input logic [31:0] v);
    exp_t e; e.tag = tag; e.mem = 1'b1; e.idx = a; e.val = v; sb.push_back(e);
  endtask

  // Hold reset and wipe all storage before loading the next program.
  task automatic clear_all();
    rst_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.DATAMEMORY.out[i] = 8'd0;
    sb.delete(); pcq.delete();
    stalls = 0; flushes = 0;
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic st);
    rst_i = 1'b1; start_i = st;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk_i); #1;
      if (pcq.size() != 0) chk($sformatf("pc@%0d", c), dut.PC.pc_o, pcq.pop_front());
      if (dut.HD.mux8_o == 1'b0) stalls++;
      if (dut.Control.jump_o || (dut.Control.branch_o && dut.EQ.data_o)) flushes++;
    end
  endtask

  task automatic drain_sb();
    exp_t e; logic [31:0] got;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.mem)
        got = {dut.DATAMEMORY.out[e.idx+3], dut.DATAMEMORY.out[e.idx+2],
               dut.DATAMEMORY.out[e.idx+1], dut.DATAMEMORY.out[e.idx]};
      else
        got = dut.Registers.register[e.idx];
      chk(e.tag, got, e.val);
    end
  endtask

  initial begin
    logic [31:0] acc;

    // Reset, then run an all-zero program.
    clear_all();
    chk("rst_pc", dut.PC.pc_o, 32'd0);
    chk("rst_mux8", {31'd0, dut.HD.mux8_o}, 32'd1);
    chk("rst_jump", {31'd0, dut.Control.jump_o}, 32'd0);
    for (int i = 1; i <= 6; i++) pcq.push_back(32'(4 * i));
    run(6, 1'b1);
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | dut.Registers.register[i];
    chk("zero_regs", acc, 32'd0);
    chk("zero_stalls", stalls, 0);

    // ALU chain with forwarding.
    clear_all();
    dut.Instruction_Memory.memory[0] = it_i(6'h08, 5'd8, 5'd0, 16'd5);
    dut.Instruction_Memory.memory[1] = it_i(6'h08, 5'd9, 5'd8, 16'd3);
    dut.Instruction_Memory.memory[2] = rt_i(6'h20, 5'd10, 5'd8, 5'd9);
    dut.Instruction_Memory.memory[3] = rt_i(6'h22, 5'd11, 5'd10, 5'd8);
    dut.Instruction_Memory.memory[4] = rt_i(6'h24, 5'd12, 5'd8, 5'd9);
    dut.Instruction_Memory.memory[5] = rt_i(6'h25, 5'd12, 5'd8, 5'd9);
    dut.Instruction_Memory.memory[6] = rt_i(6'h18, 5'd12, 5'd8, 5'd9);
    dut.Instruction_Memory.memory[7] = rt_i(6'h24, 5'd13, 5'd10, 5'd9);
    dut.Instruction_Memory.memory[8] = rt_i(6'h25, 5'd14, 5'd8, 5'd9);
    exp_reg("alu_r8", 8, 32'd5);   exp_reg("alu_r9", 9, 32'd8);
    exp_reg("alu_r10", 10, 32'd13); exp_reg("alu_r11", 11, 32'd8);
    exp_reg("alu_r12_mul", 12, 32'd40);
    exp_reg("alu_r13_and", 13, 32'd8); exp_reg("alu_r14_or", 14, 32'd13);
    run(16, 1'b1);
    drain_sb();
    chk("alu_stalls", stalls, 0);
    chk("alu_flushes", flushes, 0);

    // Load-use: one bubble, then forwarded store.
    clear_all();
    dut.DATAMEMORY.out[0] = 8'd5;
    dut.Instruction_Memory.memory[0] = it_i(6'h23, 5'd8, 5'd0, 16'd0);
    dut.Instruction_Memory.memory[1] = it_i(6'h08, 5'd9, 5'd8, 16'd1);
    dut.Instruction_Memory.memory[2] = it_i(6'h2B, 5'd9, 5'd0, 16'd4);
    exp_reg("lu_r8", 8, 32'd5); exp_reg("lu_r9", 9, 32'd6);
    exp_mem("lu_mem4", 4, 32'd6); exp_mem("lu_mem0", 0, 32'd5);
    run(12, 1'b1);
    drain_sb();
    chk("lu_stalls", stalls, 1);

    // Taken branch skips two instructions.
    clear_all();
    dut.Instruction_Memory.memory[0] = it_i(6'h08, 5'd8, 5'd0, 16'd1);
    dut.Instruction_Memory.memory[3] = it_i(6'h04, 5'd8, 5'd8, 16'd2);
    dut.Instruction_Memory.memory[4] = it_i(6'h08, 5'd9, 5'd0, 16'd7);
    dut.Instruction_Memory.memory[5] = it_i(6'h08, 5'd10, 5'd0, 16'd7);
    dut.Instruction_Memory.memory[6] = it_i(6'h08, 5'd11, 5'd0, 16'd9);
    pcq.push_back(32'd4);  pcq.push_back(32'd8);  pcq.push_back(32'd12);
    pcq.push_back(32'd16); pcq.push_back(32'd24); pcq.push_back(32'd28);
    exp_reg("br_r8", 8, 32'd1);  exp_reg("br_r9", 9, 32'd0);
    exp_reg("br_r10", 10, 32'd0); exp_reg("br_r11", 11, 32'd9);
    run(14, 1'b1);
    drain_sb();
    chk("br_flushes", flushes, 1);
    chk("br_stalls", stalls, 0);

    // Jump from 0 to 0x10.
    clear_all();
    dut.Instruction_Memory.memory[0] = {6'h02, 26'd4};
    dut.Instruction_Memory.memory[1] = it_i(6'h08, 5'd9, 5'd0, 16'd7);
    dut.Instruction_Memory.memory[4] = it_i(6'h08, 5'd8, 5'd0, 16'd3);
    pcq.push_back(32'd4); pcq.push_back(32'h10); pcq.push_back(32'h14);
    exp_reg("j_r9", 9, 32'd0); exp_reg("j_r8", 8, 32'd3);
    run(10, 1'b1);
    drain_sb();
    chk("j_flushes", flushes, 1);

    // start_i low: nothing moves; then enable and let it run.
    clear_all();
    dut.Instruction_Memory.memory[0] = it_i(6'h08, 5'd8, 5'd0, 16'd3);
    for (int i = 0; i < 10; i++) pcq.push_back(32'd0);
    exp_reg("hold_r8", 8, 32'd0);
    run(10, 1'b0);
    drain_sb();
    exp_reg("go_r8", 8, 32'd3);
    pcq.push_back(32'd4);
    run(8, 1'b1);
    drain_sb();

    // Mid-run reset returns PC to 0.
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("midrst_pc", dut.PC.pc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst_pc4", dut.PC.pc_o, 32'd4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
